rf_set_sb: RTL
==============

Name: rf_set_sb

Overview:
- Parametrised register file for the small CPU datapath, extending the fixed 4x4-bit register set.
- Generalises width and register count.
- Adds a per-register busy scoreboard and a single-outstanding load-completion handshake for multi-cycle (indirect) loads.
- Adds a registered output-port strobe.
- Sits between decode/ALU and the memory/IO path; feeds ALU operands A/B and the IO output port.

Parameters:
- WIDTH, 4, data width of every register.
- NREG, 4, number of registers (2..16).
- AW, 2, register address width (must satisfy 2^AW >= NREG).
- IN_REG, 2, index of the input-port register (written only via InE).
- OUT_REG, 3, index of the register mirrored on OutD.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- RA  in  AW  read address, port A
- RB  in  AW  read address, port B
- A  out  WIDTH  register[RA], combinational
- B  out  WIDTH  register[RB], combinational
- A_busy  out  1  busy[RA], combinational
- B_busy  out  1  busy[RB], combinational
- RE  in  1  ALU write enable
- WR  in  AW  ALU write address
- WRD  in  WIDTH  ALU write data
- LD_ISSUE  in  1  load issued; reserve LD_DST
- LD_DST  in  AW  load destination
- LD_READY  out  1  load slot waiting for data
- LD_VALID  in  1  load data valid
- LD_DATA  in  WIDTH  load data
- LD_ERR  out  1  sticky protocol error
- InD  in  WIDTH  input-port data
- InE  in  1  input-port write enable
- OutD  out  WIDTH  register[OUT_REG]
- OutV  out  1  one-cycle pulse after OUT_REG is written
- R_flat  out  NREG*WIDTH  all registers; register i at bits [i*WIDTH +: WIDTH]

Behaviour:
- Reset (reset=0, async):
  - all registers 0 and all busy bits 0
  - FSM enters IDLE
  - LD_READY=0, OutV=0, LD_ERR=0
  - reset mid-load abandons the load; busy bits are cleared.
- Reads: A/B/busy flags are combinational from stored state. There is no write-to-read bypass: a write is visible the cycle after its clock edge.
- Address range: addresses >= NREG read as 0 with busy=0. Writes to such addresses are ignored.
- Load FSM, two states: IDLE, WAIT.
  - IDLE: LD_READY=0. On LD_ISSUE with LD_DST valid and != IN_REG: set busy[LD_DST], latch the destination, go to WAIT. If LD_DST == IN_REG or out of range: set LD_ERR, stay in IDLE.
  - WAIT: LD_READY=1. On LD_VALID: write LD_DATA to the latched destination, clear its busy bit, return to IDLE.
  - LD_ISSUE while in WAIT (including the completion cycle): ignored, sets LD_ERR.
  - LD_VALID while in IDLE: ignored, no error.
  - Load latency: issue edge to earliest completion edge is 1 cycle. Busy is high from the cycle after issue through the completion cycle.
- ALU write (RE=1): writes WRD to register[WR] at the clock edge.
  - WR == IN_REG: write ignored.
  - Same cycle and same register as a load completion: load wins, ALU write dropped.
  - ALU write to a busy register is permitted; busy stays set and the later completion overwrites it.
- Input port: InE=1 writes InD to register[IN_REG], independent of all other writes in the same cycle.
- OutV: registered. High for exactly one cycle after any edge that commits a write to OUT_REG (ALU or load), even if the value is unchanged. Back-to-back writes hold OutV high continuously.
- LD_ERR clears only on reset.
- Arithmetic: none. All data paths are pass-through at WIDTH bits.

Test Plan:
- Reset then write/read: release reset; RE=1, WR=1, WRD=4'hA. Next cycle RA=1 -> A=4'hA; RB=0 -> B=0; busy flags 0.
- Input-port isolation: InE=1, InD=4'h5 plus RE=1, WR=2, WRD=4'hF in the same cycle -> R2=4'h5.
- Output strobe: RE=1, WR=3, WRD=4'h7 for 1 cycle -> OutD=4'h7 from the next cycle; OutV high for exactly that 1 cycle; an identical second write pulses OutV again.
- Load handshake:
  - LD_ISSUE, LD_DST=0 -> A_busy (RA=0)=1 and LD_READY=1 next cycle.
  - Hold 3 cycles, then LD_VALID with LD_DATA=4'hC -> R0=4'hC, busy 0, LD_READY 0 on the following cycle.
- Collision and errors:
  - During WAIT on dest 3, same-cycle ALU write WRD=4'h1 and LD_VALID, LD_DATA=4'h9 -> R3=4'h9, OutV pulses.
  - A second LD_ISSUE during WAIT -> LD_ERR=1 and stays 1.
  - LD_ISSUE with LD_DST=2 -> LD_ERR=1, no busy bit set.
- Reset mid-load: assert reset while in WAIT -> immediately all registers 0, busy 0, LD_READY 0, LD_ERR 0. A subsequent LD_VALID is ignored.

Source files
------------

// File: rtl/rf_set_sb.sv
// rf_set_sb: parametrised register file with per-register busy scoreboard,
// a single-outstanding load-completion handshake and a registered strobe
// that marks writes to the output-port register.
module rf_set_sb #(
  parameter int WIDTH   = 4,
  parameter int NREG    = 4,
  parameter int AW      = 2,
  parameter int IN_REG  = 2,
  parameter int OUT_REG = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         RA,
  input  logic [AW-1:0]         RB,
  output logic [WIDTH-1:0]      A,
  output logic [WIDTH-1:0]      B,
  output logic                  A_busy,
  output logic                  B_busy,
  input  logic                  RE,
  input  logic [AW-1:0]         WR,
  input  logic [WIDTH-1:0]      WRD,
  input  logic                  LD_ISSUE,
  input  logic [AW-1:0]         LD_DST,
  output logic                  LD_READY,
  input  logic                  LD_VALID,
  input  logic [WIDTH-1:0]      LD_DATA,
  output logic                  LD_ERR,
  input  logic [WIDTH-1:0]      InD,
  input  logic                  InE,
  output logic [WIDTH-1:0]      OutD,
  output logic                  OutV,
  output logic [NREG*WIDTH-1:0] R_flat
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ld_state_t;

  ld_state_t             state_q;
  logic [NREG*WIDTH-1:0] rf_q;
  logic [NREG-1:0]       busy_q;
  logic [AW-1:0]         ld_dst_p1;
  logic                  ld_ready_q;
  logic                  ld_err_q;
  logic                  out_vld_p1;

  logic                  ld_accept;
  logic                  ld_reject;
  logic                  ld_done;
  logic                  alu_we;
  logic                  out_commit;

  // True when the address names an implemented register.
  function automatic logic addr_ok(input logic [AW-1:0] addr);
    return 32'(addr) < 32'(NREG);
  endfunction

  // Register read mux; unimplemented addresses read as zero.
  function automatic logic [WIDTH-1:0] rd_data(input logic [AW-1:0] addr,
                                               input logic [NREG*WIDTH-1:0] rf);
    logic [WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr == AW'(i)) d = rf[i*WIDTH +: WIDTH];
    end
    return d;
  endfunction

  // Busy-bit read mux; unimplemented addresses are never busy.
  function automatic logic rd_busy(input logic [AW-1:0] addr,
                                   input logic [NREG-1:0] bsy);
    logic b;
    b = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (addr == AW'(i)) b = bsy[i];
    end
    return b;
  endfunction

  assign A        = rd_data(RA, rf_q);
  assign B        = rd_data(RB, rf_q);
  assign A_busy   = rd_busy(RA, busy_q);
  assign B_busy   = rd_busy(RB, busy_q);
  assign OutD     = rf_q[OUT_REG*WIDTH +: WIDTH];
  assign OutV     = out_vld_p1;
  assign LD_READY = ld_ready_q;
  assign LD_ERR   = ld_err_q;
  assign R_flat   = rf_q;

  // Decode this cycle's load/ALU events; a load completion beats an ALU write
  // to the same register, and the input-port register is never ALU/load writable.
  always_comb begin
    ld_accept  = (state_q == IDLE) && LD_ISSUE && addr_ok(LD_DST) &&
                 (LD_DST != AW'(IN_REG));
    ld_reject  = LD_ISSUE && !ld_accept;
    ld_done    = (state_q == WAIT) && LD_VALID;
    alu_we     = RE && addr_ok(WR) && (WR != AW'(IN_REG)) &&
                 !(ld_done && (WR == ld_dst_p1));
    out_commit = (ld_done && (ld_dst_p1 == AW'(OUT_REG))) ||
                 (alu_we && (WR == AW'(OUT_REG))) ||
                 (InE && (IN_REG == OUT_REG));
  end

  // Load handshake FSM with registered LD_READY, latched destination and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ld_ready_q <= 1'b0;
      ld_dst_p1  <= '0;
      ld_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ld_accept) begin
            state_q    <= WAIT;
            ld_ready_q <= 1'b1;
            ld_dst_p1  <= LD_DST;
          end
        end
        WAIT: begin
          if (ld_done) begin
            state_q    <= IDLE;
            ld_ready_q <= 1'b0;
          end
        end
      endcase
      if (ld_reject) ld_err_q <= 1'b1;
    end
  end

  // Register storage: load completion, ALU write and input-port write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ld_done && (ld_dst_p1 == AW'(i))) begin
          rf_q[i*WIDTH +: WIDTH] <= LD_DATA;
        end else if (alu_we && (WR == AW'(i))) begin
          rf_q[i*WIDTH +: WIDTH] <= WRD;
        end
        if (InE && (i == IN_REG)) rf_q[i*WIDTH +: WIDTH] <= InD;
      end
    end
  end

  // Scoreboard: reserve on accepted issue, release on completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (ld_accept && (LD_DST == AW'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (ld_done && (ld_dst_p1 == AW'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // One-cycle strobe following any committed write to the output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_p1 <= 1'b0;
    end else begin
      out_vld_p1 <= out_commit;
    end
  end

endmodule
